i2c_master: RTL and testbench

- Single-master I2C bus controller that generates START, 7-bit address plus R/W, one data byte, ACK/NACK and STOP.
- It is the upstream stage of our i2c_slave: it drives the bus the slave samples, for board-level loopback and self-test.
- The local side uses a one-byte command/response handshake.
- Bus pins are open-drain: the block only ever pulls low or releases.

---
 rtl/i2c_master.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-master I2C controller: START, 7-bit address + R/W, one data byte,
// ACK/NACK handling and STOP. Open-drain bus: outputs only pull low or release.
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl_oe,
  input  logic       scl_in,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RNACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          hold, tick, sample;
  logic [7:0]    abyte_d;

  // Quarter sequencing, bit counting and state transitions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdat_d    = wdat_q;
    shift_d   = shift_q;
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    // A slave holding SCL low in Q2 freezes the divider until SCL is seen high.
    hold   = (qtr_q == 2'd2) && !scl_in;
    tick   = (cnt_q == CNT_MAX) && !hold;
    sample = (qtr_q == 2'd3) && (cnt_q == '0);

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      qtr_d = '0;
      // done_q high means we just finished; a start in that cycle is dropped.
      if (start && !done_q) begin
        addr_d  = addr;
        rw_d    = rw;
        wdat_d  = wr_data;
        busy_d  = 1'b1;
        nack_d  = 1'b0;
        state_d = S_START;
      end
    end else begin
      if (!hold) cnt_d = tick ? '0 : cnt_q + CW'(1);
      // Address ACK, write ACK and read bits all shift through one register;
      // the ACK decision looks at bit 0 after its sample.
      if (sample && (state_q == S_AACK || state_q == S_WACK || state_q == S_RDATA))
        shift_d = {shift_q[6:0], sda_in};
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          case (state_q)
            S_START: begin
              state_d = S_ADDR;
              bit_d   = 3'd7;
            end
            S_ADDR: begin
              if (bit_q == 3'd0) state_d = S_AACK;
              else bit_d = bit_q - 3'd1;
            end
            S_AACK: begin
              bit_d = 3'd7;
              if (shift_q[0]) begin
                nack_d  = 1'b1;
                state_d = S_STOP;
              end else begin
                state_d = rw_q ? S_RDATA : S_WDATA;
              end
            end
            S_WDATA: begin
              if (bit_q == 3'd0) state_d = S_WACK;
              else bit_d = bit_q - 3'd1;
            end
            S_WACK: begin
              nack_d  = shift_q[0];
              state_d = S_STOP;
            end
            S_RDATA: begin
              if (bit_q == 3'd0) state_d = S_RNACK;
              else bit_d = bit_q - 3'd1;
            end
            S_RNACK: state_d = S_STOP;
            S_STOP: begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              if (rw_q) rd_data_d = shift_q;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  // Bus drive computed from the next state so the pins are registered and
  // change in the same cycle as the quarter they belong to.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    abyte_d  = {addr_d, rw_d};
    case (state_d)
      S_START: sda_oe_d = qtr_d[1];
      S_ADDR: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = !abyte_d[bit_d];
      end
      S_WDATA: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = !wdat_d[bit_d];
      end
      S_AACK, S_WACK, S_RDATA, S_RNACK: scl_oe_d = !qtr_d[1];
      S_STOP: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = (qtr_d != 2'd3);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdat_q    <= '0;
      shift_q   <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdat_q    <= wdat_d;
      shift_q   <= shift_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign nack    = nack_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with an open-drain bus and a behavioural slave.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy, done, nack;
  logic       scl_oe, scl_in, sda_oe, sda_in;

  i2c_master #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
    .nack(nack), .scl_oe(scl_oe), .scl_in(scl_in), .sda_oe(sda_oe),
    .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  // Slave/bus configuration (written only by the stimulus block)
  logic       resp = 1'b0, rcfg = 1'b0, arm = 1'b0, clr = 1'b1;
  logic [7:0] rbyte = 8'h00;

  // Monitor state
  int   busy_cyc, done_cnt, rises, starts, stops, bidx, scnt;
  logic prev_scl, prev_sda;
  logic bus_bits [0:31];
  logic oe_bits  [0:31];
  logic slave_pull, stretch;
  logic [2:0] ri;

  int comps = 0;
  int fails = 0;

  always_comb begin
    stretch = arm && (bidx == 12) && (scnt < 20) && !scl_oe;
    slave_pull = 1'b0;
    ri = 3'(16 - bidx);
    if (resp) begin
      if (bidx == 8) slave_pull = 1'b1;
      else if (rcfg && bidx >= 9 && bidx <= 16) slave_pull = !rbyte[ri];
      else if (!rcfg && bidx == 17) slave_pull = 1'b1;
    end
  end

  assign scl_in = !scl_oe && !stretch;
  assign sda_in = !sda_oe && !slave_pull;

  always @(posedge clk) begin
    if (clr) begin
      busy_cyc <= 0; done_cnt <= 0; rises <= 0; starts <= 0; stops <= 0;
      bidx <= -1; scnt <= 0;
    end else begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (stretch) scnt <= scnt + 1;
      if (scl_in && !prev_scl) begin
        if (rises < 32) begin
          bus_bits[rises] <= sda_in;
          oe_bits[rises]  <= sda_oe;
        end
        rises <= rises + 1;
      end
      if (!scl_in && prev_scl) bidx <= bidx + 1;
      if (scl_in && prev_scl && prev_sda && !sda_in) begin
        starts <= starts + 1;
        bidx   <= -1;
      end
      if (scl_in && prev_scl && !prev_sda && sda_in) stops <= stops + 1;
    end
    prev_scl <= scl_in;
    prev_sda <= sda_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] bus_vec();
    logic [17:0] v = '0;
    for (int i = 0; i < 18; i++) v = {v[16:0], bus_bits[i]};
    return v;
  endfunction

  function automatic logic [17:0] oe_vec();
    logic [17:0] v = '0;
    for (int i = 0; i < 18; i++) v = {v[16:0], oe_bits[i]};
    return v;
  endfunction

  // One transaction; optional second start pulse and a start in the done cycle.
  task automatic run_txn(input string tag, input logic [6:0] a, input logic r,
                         input logic [7:0] d, input logic rsp, input logic [7:0] rb,
                         input logic st, input int second_at, input logic start_on_done);
    int cyc;
    @(negedge clk);
    resp = rsp; rcfg = r; rbyte = rb; arm = st; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    addr = a; rw = r; wr_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; addr = ~a; rw = ~r; wr_data = ~d;
    cyc = 0;
    while (!done && cyc < 3000) begin
      start = (second_at != 0) && (cyc == second_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (start_on_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_start_on_done_ignored"}, {31'd0, busy}, 32'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_nack",   {31'd0, nack},   32'd0);
    check("rst_rdata",  {24'd0, rd_data}, 32'd0);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    rst = 1'b1;

    // Write 0xA5 to 0x50, slave ACKs
    run_txn("wr", 7'h50, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    check("wr_busy_cycles", busy_cyc, 32'd320);
    check("wr_done_pulses", done_cnt, 32'd1);
    check("wr_nack", {31'd0, nack}, 32'd0);
    check("wr_bits", {14'd0, bus_vec()}, {14'd0, 8'hA0, 1'b0, 8'hA5, 1'b0});
    check("wr_oe_ack", {30'd0, oe_bits[8], oe_bits[17]}, 32'd0);
    check("wr_scl_rises", rises, 32'd19);
    check("wr_start_stop", {starts[15:0], stops[15:0]}, {16'd1, 16'd1});

    // Read one byte 0x3C from 0x50
    run_txn("rd", 7'h50, 1'b1, 8'h00, 1'b1, 8'h3C, 1'b0, 0, 1'b0);
    check("rd_data", {24'd0, rd_data}, {24'd0, 8'h3C});
    check("rd_busy_cycles", busy_cyc, 32'd320);
    check("rd_nack", {31'd0, nack}, 32'd0);
    check("rd_bits", {14'd0, bus_vec()}, {14'd0, 8'hA1, 1'b0, 8'h3C, 1'b1});
    check("rd_oe_released", {14'd0, oe_vec() & 18'h1FF}, 32'd0);
    check("rd_done_pulses", done_cnt, 32'd1);

    // Address NACK: nobody answers at 0x23
    run_txn("nk", 7'h23, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    check("nk_nack", {31'd0, nack}, 32'd1);
    check("nk_busy_cycles", busy_cyc, 32'd176);
    check("nk_scl_rises", rises, 32'd10);
    check("nk_bits", {23'd0, bus_vec() >> 9}, {23'd0, 8'h46, 1'b1});
    check("nk_stop_sda_low", {31'd0, bus_bits[9]}, 32'd0);
    check("nk_start_stop", {starts[15:0], stops[15:0]}, {16'd1, 16'd1});

    // Clock stretching on write data bit 3
    run_txn("st", 7'h50, 1'b0, 8'h96, 1'b1, 8'h00, 1'b1, 0, 1'b0);
    check("st_busy_cycles", busy_cyc, 32'd340);
    check("st_stretch_len", scnt, 32'd20);
    check("st_bits", {14'd0, bus_vec()}, {14'd0, 8'hA0, 1'b0, 8'h96, 1'b0});
    check("st_nack", {31'd0, nack}, 32'd0);
    check("st_scl_rises", rises, 32'd19);
    arm = 1'b0;

    // Reset during address bit 4
    @(negedge clk);
    resp = 1'b1; rcfg = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; addr = 7'h50; rw = 1'b0; wr_data = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (bidx != 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rs_reached_bit4", bidx, 32'd4);
    check("rs_pre_oe", {30'd0, scl_oe, sda_oe}, 32'd3);
    rst = 1'b0;
    #1;
    check("rs_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rs_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rs_busy",   {31'd0, busy},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_txn("rw", 7'h50, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    check("rw_bits", {14'd0, bus_vec()}, {14'd0, 8'hA0, 1'b0, 8'h5A, 1'b0});
    check("rw_busy_cycles", busy_cyc, 32'd320);
    check("rw_nack", {31'd0, nack}, 32'd0);

    // Second start during a write, plus start in the done cycle
    run_txn("ds", 7'h50, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b0, 10, 1'b1);
    check("ds_done_pulses", done_cnt, 32'd1);
    check("ds_start_stop", {starts[15:0], stops[15:0]}, {16'd1, 16'd1});
    check("ds_busy_cycles", busy_cyc, 32'd320);
    check("ds_bits", {14'd0, bus_vec()}, {14'd0, 8'hA0, 1'b0, 8'hC3, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
